// File: rtl/audio_pkg.sv
// Shared audio constants, stereo payload type and slot decode helpers.
package audio_pkg;

    localparam int unsigned SAMPLE_W         = 16;
    localparam int unsigned FRAME_BITS       = 32;
    localparam int unsigned SLOT_W           = $clog2(FRAME_BITS);
    localparam int unsigned DEFAULT_HALF_DIV = 35;

    localparam int unsigned WS_RISE_SLOT     = 15;
    localparam int unsigned WS_FALL_SLOT     = 31;
    localparam int unsigned SYNC_RISE_SLOT   = 16;

    // One stereo frame: left channel in the upper half.
    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_sample_t;

    // WS leads each channel's MSB by one slot, so it is high for slots 15..30.
    function automatic logic ws_for_slot(input logic [SLOT_W-1:0] k);
        return (k >= SLOT_W'(WS_RISE_SLOT)) && (k < SLOT_W'(WS_FALL_SLOT));
    endfunction

    // Frame sync is high for the right-channel half of the frame.
    function automatic logic sync_for_slot(input logic [SLOT_W-1:0] k);
        return k >= SLOT_W'(SYNC_RISE_SLOT);
    endfunction

endpackage

// File: rtl/i2s_clock_divider.sv
// Bit clock generator: toggles bclk every HALF_DIV cycles and flags the 1->0 toggle.
module i2s_clock_divider
    import audio_pkg::*;
#(
    parameter int unsigned HALF_DIV = DEFAULT_HALF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic fall_c
);

    localparam int unsigned CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bclk_q, bclk_d;
    logic             tc;

    // Count 0..HALF_DIV-1, wrap and toggle the bit clock at terminal count.
    always_comb begin
        tc     = (cnt_q == CNT_W'(HALF_DIV - 1));
        cnt_d  = cnt_q + CNT_W'(1);
        bclk_d = bclk_q;
        if (tc) begin
            cnt_d  = '0;
            bclk_d = ~bclk_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk   = bclk_q;
    // Combinational so the consumer registers update on the same edge as bclk falls.
    assign fall_c = tc & bclk_q;

endmodule

// File: rtl/i2s.sv
// Philips-format stereo I2S transmitter with internal bit-clock divider and frame sync.
module i2s
    import audio_pkg::*;
#(
    parameter int unsigned HALF_DIV = DEFAULT_HALF_DIV
) (
    input  logic                  MasterCLK,
    input  logic                  Reset,
    input  logic [FRAME_BITS-1:0] InputData,
    output logic                  I2S_CLK,
    output logic                  I2S_WS,
    output logic                  I2S_DATA,
    output logic                  SyncCLK
);

    logic              fall_c;
    logic [SLOT_W-1:0] k_q, k_d;
    stereo_sample_t    shift_q, shift_d;
    logic              data_q, data_d;
    logic              ws_q, ws_d;
    logic              sync_q, sync_d;

    i2s_clock_divider #(
        .HALF_DIV (HALF_DIV)
    ) u_clock_divider (
        .clk    (MasterCLK),
        .rst_n  (Reset),
        .bclk   (I2S_CLK),
        .fall_c (fall_c)
    );

    // Advance the slot on each bit-clock fall; load the frame when wrapping into slot 0.
    always_comb begin
        k_d     = k_q;
        shift_d = shift_q;
        data_d  = data_q;
        ws_d    = ws_q;
        sync_d  = sync_q;
        if (fall_c) begin
            k_d = k_q + SLOT_W'(1);
            if (k_q == SLOT_W'(FRAME_BITS - 1)) begin
                shift_d = stereo_sample_t'(InputData);
                data_d  = InputData[FRAME_BITS-1];
            end else begin
                data_d  = shift_q[SLOT_W'(FRAME_BITS - 1) - k_d];
            end
            ws_d   = ws_for_slot(k_d);
            sync_d = sync_for_slot(k_d);
        end
    end

    // Slot, frame and output registers; k starts at 31 so the first fall loads.
    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            k_q     <= SLOT_W'(FRAME_BITS - 1);
            shift_q <= '0;
            data_q  <= 1'b0;
            ws_q    <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            k_q     <= k_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ws_q    <= ws_d;
            sync_q  <= sync_d;
        end
    end

    assign I2S_DATA = data_q;
    assign I2S_WS   = ws_q;
    assign SyncCLK  = sync_q;

endmodule

// File: tb/tb_i2s.sv
// Directed bench for the i2s transmitter at HALF_DIV=35.
module tb_i2s;

    logic        MasterCLK = 1'b0;
    logic        Reset     = 1'b0;
    logic [31:0] InputData = 32'h0;
    logic        I2S_CLK;
    logic        I2S_WS;
    logic        I2S_DATA;
    logic        SyncCLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit   mon_en   = 1'b0;
    int   edge_bad = 0;
    logic last_clk, last_ws, last_sync, last_data;
    int   sync_rise_cyc = -1;

    i2s #(
        .HALF_DIV (35)
    ) dut (
        .MasterCLK (MasterCLK),
        .Reset     (Reset),
        .InputData (InputData),
        .I2S_CLK   (I2S_CLK),
        .I2S_WS    (I2S_WS),
        .I2S_DATA  (I2S_DATA),
        .SyncCLK   (SyncCLK)
    );

    always #5 MasterCLK = ~MasterCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // One master cycle; sample 1 time unit after the rising edge.
    // While monitoring, WS/SyncCLK/DATA may only move on a bit-clock fall.
    task automatic step();
        @(posedge MasterCLK);
        #1;
        cyc++;
        if (mon_en) begin
            if ((I2S_WS !== last_ws || SyncCLK !== last_sync || I2S_DATA !== last_data)
                && !(last_clk === 1'b1 && I2S_CLK === 1'b0))
                edge_bad++;
        end
        last_clk  = I2S_CLK;
        last_ws   = I2S_WS;
        last_sync = SyncCLK;
        last_data = I2S_DATA;
    endtask

    // Step until I2S_CLK reaches lvl; n = cycles taken, -1 on timeout.
    task automatic wait_clk(input logic lvl, output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (I2S_CLK === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    // Starting just after the slot-0 fall, capture one frame at bit-clock rises.
    // Ends just after the next slot-0 fall.
    task automatic run_frame(input logic [31:0] mid_word, input bit mid_en,
                             input logic [31:0] sync_word,
                             output logic [31:0] data_w, output logic [31:0] ws_w,
                             output logic [31:0] sync_w, output int half_bad);
        int   n;
        logic prev_s;
        data_w   = '0;
        ws_w     = '0;
        sync_w   = '0;
        half_bad = 0;
        for (int k = 0; k < 32; k++) begin
            wait_clk(1'b1, n);
            if (n != 35) half_bad++;
            data_w[31-k] = I2S_DATA;
            ws_w[31-k]   = I2S_WS;
            sync_w[31-k] = SyncCLK;
            prev_s       = SyncCLK;
            wait_clk(1'b0, n);
            if (n != 35) half_bad++;
            if (mid_en && k + 1 == 5) InputData = mid_word;
            if (prev_s === 1'b0 && SyncCLK === 1'b1) begin
                sync_rise_cyc = cyc;
                InputData     = sync_word;
            end
        end
    endtask

    initial begin
        int          n1, n2, hb, rise1;
        logic [31:0] d, w, s;

        Reset     = 1'b0;
        InputData = 32'hA5A5_0F0F;
        repeat (10) step();
        check("rst_clk",  32'(I2S_CLK),  32'h0);
        check("rst_ws",   32'(I2S_WS),   32'h0);
        check("rst_data", 32'(I2S_DATA), 32'h0);
        check("rst_sync", 32'(SyncCLK),  32'h0);

        Reset = 1'b1;
        wait_clk(1'b1, n1);
        check("first_rise_cyc", 32'(n1), 32'd35);
        wait_clk(1'b0, n2);
        check("first_fall_cyc", 32'(n1 + n2), 32'd70);
        check("load_msb",  32'(I2S_DATA), 32'h1);
        check("load_ws",   32'(I2S_WS),   32'h0);
        check("load_sync", 32'(SyncCLK),  32'h0);

        // Frame 1: mid-frame change at slot 5 must not disturb the frame in flight.
        mon_en = 1'b1;
        run_frame(32'h1234_5678, 1'b1, 32'h8000_7FFF, d, w, s, hb);
        check("f1_data",  d, 32'hA5A5_0F0F);
        check("f1_ws",    w, 32'h0001_FFFE);
        check("f1_sync",  s, 32'h0000_FFFF);
        check("f1_halves", 32'(hb), 32'h0);
        rise1 = sync_rise_cyc;

        // Frame 2: carries the word presented on the SyncCLK rise.
        run_frame(32'h0, 1'b0, 32'h8000_7FFF, d, w, s, hb);
        check("f2_data",  d, 32'h8000_7FFF);
        check("f2_ws",    w, 32'h0001_FFFE);
        check("f2_halves", 32'(hb), 32'h0);
        check("sync_period", 32'(sync_rise_cyc - rise1), 32'd2240);
        check("edges_on_fall", 32'(edge_bad), 32'h0);

        // Frame 3: reset at slot 20 while I2S_CLK is high.
        for (int k = 0; k < 20; k++) begin
            wait_clk(1'b1, n1);
            wait_clk(1'b0, n2);
        end
        wait_clk(1'b1, n1);
        mon_en = 1'b0;
        check("pre_rst_clk",  32'(I2S_CLK),  32'h1);
        check("pre_rst_ws",   32'(I2S_WS),   32'h1);
        check("pre_rst_sync", 32'(SyncCLK),  32'h1);
        check("pre_rst_data", 32'(I2S_DATA), 32'h1);
        Reset = 1'b0;
        #1;
        check("mid_rst_clk",  32'(I2S_CLK),  32'h0);
        check("mid_rst_ws",   32'(I2S_WS),   32'h0);
        check("mid_rst_sync", 32'(SyncCLK),  32'h0);
        check("mid_rst_data", 32'(I2S_DATA), 32'h0);
        repeat (5) step();
        InputData = 32'h0F0F_F0F0;
        Reset     = 1'b1;
        wait_clk(1'b1, n1);
        wait_clk(1'b0, n2);
        check("rerun_fall_cyc", 32'(n1 + n2), 32'd70);
        check("rerun_msb", 32'(I2S_DATA), 32'h0);
        run_frame(32'h0, 1'b0, 32'h0F0F_F0F0, d, w, s, hb);
        check("f4_data", d, 32'h0F0F_F0F0);
        check("f4_sync", s, 32'h0000_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s.md
# i2s

Stereo I2S transmitter for the audio peripheral. It derives the serial bit clock from the 100 MHz master clock with an internal divider; this replaces a separate clock-manager output. Once per frame it samples one 32-bit stereo word (left in the upper half, right in the lower half) and shifts it out MSB-first in Philips I2S format. It also provides a frame-rate sync clock so the mixer can present the next sample in time.

## Interface
- HALF_DIV, 35: MasterCLK cycles per I2S_CLK half-period (BCLK = 100 MHz / 70 ≈ 1.4286 MHz; fs = BCLK/32 ≈ 44.64 kHz); minimum 2.
- MasterCLK  in  1  system clock, 100 MHz, all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- InputData  in  32  [31:16] left sample, [15:0] right sample, two's complement.
- I2S_CLK  out  1  serial bit clock to DAC.
- I2S_WS  out  1  word select: 0 = left, 1 = right.
- I2S_DATA  out  1  serial data, MSB-first.
- SyncCLK  out  1  frame-rate square wave; the rising edge signals that the producer may update InputData.

## Operation
- Divider counter runs 0..HALF_DIV-1. At terminal count it wraps to 0 and toggles I2S_CLK.
- A falling event is the toggle that drives I2S_CLK from 1 to 0. Each falling event advances the slot index k, which wraps 31 to 0.
- On the falling event entering k=0:
  - shift register loads InputData;
  - I2S_DATA = InputData[31] on the same edge.
- On the falling event entering k=1..31: I2S_DATA = shift[31-k].
  - Slots 0..15 carry the left sample, MSB at slot 0.
  - Slots 16..31 carry the right sample, MSB at slot 16.
- I2S_WS for slot k is 1 when k is in 15..30, else 0. WS therefore leads the first bit of each channel by one BCLK (Philips format).
- SyncCLK is 1 for slots 16..31 and 0 for slots 0..15. Its rising edge falls exactly half a frame before the next load.
- InputData is ignored at every edge except the slot-0 load. Mid-frame changes do not affect the frame in flight.
- The DAC samples on the I2S_CLK rising edge, which falls mid-bit by construction.

## Timing
- Reset values: I2S_CLK=0, I2S_WS=0, I2S_DATA=0, SyncCLK=0, divider=0, k=31, shift=0.
- After reset release:
  - first I2S_CLK rise at cycle HALF_DIV;
  - first falling event (entering slot 0, load) at cycle 2·HALF_DIV.
- All outputs are registered. They change only on the MasterCLK edge of a toggle (I2S_CLK) or falling event (WS, DATA, SyncCLK).
- Load latency: InputData sampled at the slot-0 edge; MSB is visible on I2S_DATA after that same edge, with no extra cycle.
- Frame length is exactly 64·HALF_DIV MasterCLK cycles and has no drift.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). After release, operation restarts from the first-load sequence above; the partial frame is discarded.

## Structure
- Shared package audio_pkg holds:
  - SAMPLE_W=16 and FRAME_BITS=32;
  - DEFAULT_HALF_DIV=35;
  - helper constants for slot boundaries (WS_RISE_SLOT=15, WS_FALL_SLOT=31, SYNC_RISE_SLOT=16).
- One sub-module, i2s_clock_divider, generates I2S_CLK plus a single-cycle falling-event strobe. The top holds the slot counter, shift register and WS/SyncCLK decode.

## Test plan
- Reset: hold Reset=0 for 10 cycles → all outputs 0. Release → I2S_CLK rises at cycle 35, falls at cycle 70, and the I2S_CLK period is 70 cycles thereafter.
- Serialization: InputData=0xA5A5_0F0F at the first load → 32 bits sampled on I2S_CLK rising edges read 1010_0101_1010_0101_0000_1111_0000_1111.
- Word select: across one frame, WS=0 for slots 0..14 and 31, and WS=1 for slots 15..30. WS transitions coincide with I2S_CLK falling edges only.
- Sync: SyncCLK rises at slot 16 and falls at slot 0, giving a 2240-cycle period at HALF_DIV=35. Update InputData to 0x8000_7FFF on each SyncCLK rise → the next frame serializes 0x8000_7FFF.
- Mid-frame change: change InputData at slot 5 → the current frame still carries the value loaded at slot 0.
- Mid-frame reset: assert Reset at slot 20 → outputs 0 immediately. After release, the first load occurs 70 cycles later with the current InputData.
